// File: rtl/sram_uart_dump_pkg.sv
`default_nettype none
// ============================================================================
// sram_uart_dump_pkg : shared states and defaults for the SRAM-to-UART dump
// Rev 1.0
// ============================================================================
package sram_uart_dump_pkg;

  localparam int c_DEFAULT_CLKS_PER_BIT      = 434;  // 50 MHz / 115200 baud
  localparam int c_DEFAULT_SRAM_READ_LATENCY = 3;
  localparam int c_DEFAULT_ADDR_W            = 18;
  localparam int c_UART_FRAME_BITS           = 10;   // start + 8 data + stop

  typedef enum logic [2:0] {
    S_DUMP_IDLE  = 3'd0,
    S_DUMP_FETCH = 3'd1,
    S_DUMP_WAIT  = 3'd2,
    S_DUMP_TX_HI = 3'd3,
    S_DUMP_TX_LO = 3'd4,
    S_DUMP_DONE  = 3'd5
  } dump_state_type;

endpackage
`default_nettype wire

// File: rtl/sram_uart_dump_if.sv
`default_nettype none
// ============================================================================
// sram_uart_dump_if : request, SRAM read port and serial line of the dump block
// Rev 1.0
// ============================================================================
interface sram_uart_dump_if #(
  parameter int ADDR_W = sram_uart_dump_pkg::c_DEFAULT_ADDR_W
) ();

  logic              Start;
  logic [ADDR_W-1:0] Start_address;
  logic [ADDR_W-1:0] Word_count;
  logic              Busy;
  logic              Done;
  logic [ADDR_W-1:0] SRAM_address;
  logic              SRAM_we_n;
  logic [15:0]       SRAM_read_data;
  logic              UART_TX_O;

  modport master (
    output Start, Start_address, Word_count, SRAM_read_data,
    input  Busy, Done, SRAM_address, SRAM_we_n, UART_TX_O
  );

  modport slave (
    input  Start, Start_address, Word_count, SRAM_read_data,
    output Busy, Done, SRAM_address, SRAM_we_n, UART_TX_O
  );

endinterface
`default_nettype wire

// File: rtl/sram_uart_dump_uart_tx_byte.sv
`default_nettype none
// ============================================================================
// uart_tx_byte : 8N1 byte serializer; reloads on the last stop cycle with no gap
// Rev 1.0
// ============================================================================
module uart_tx_byte
  import sram_uart_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT
) (
  input  wire logic       Clock,
  input  wire logic       Resetn,
  input  wire logic       Load,
  input  wire logic [7:0] Data,
  output wire logic       TX,
  output wire logic       Frame_done
);

  localparam int                  c_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]          c_STOP_BIT  = 4'(c_UART_FRAME_BITS - 1);

  logic [c_BAUD_W-1:0] r_baud;
  logic [3:0]          r_bit;
  logic [8:0]          r_shift;
  logic                r_active;
  logic                r_tx;
  logic                w_bit_end;

  assign w_bit_end  = r_active && (r_baud == c_BAUD_LAST);
  assign Frame_done = w_bit_end && (r_bit == c_STOP_BIT);
  assign TX         = r_tx;

  // The stop bit rides in the top of the shift register, so after eight data
  // shifts the line naturally goes to 1 for the stop bit.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '1;
      r_active <= 1'b0;
      r_tx     <= 1'b1;
    end else if (Load) begin
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= {1'b1, Data};
      r_active <= 1'b1;
      r_tx     <= 1'b0;
    end else if (Frame_done) begin
      r_baud   <= '0;
      r_bit    <= '0;
      r_active <= 1'b0;
      r_tx     <= 1'b1;
    end else if (w_bit_end) begin
      r_baud  <= '0;
      r_bit   <= r_bit + 1'b1;
      r_tx    <= r_shift[0];
      r_shift <= {1'b1, r_shift[8:1]};
    end else if (r_active) begin
      r_baud <= r_baud + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_uart_dump.sv
`default_nettype none
// ============================================================================
// sram_uart_dump : reads a block of SRAM words and sends each high byte then low byte over UART
// Rev 1.0
// ============================================================================
module sram_uart_dump
  import sram_uart_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT      = c_DEFAULT_CLKS_PER_BIT,
  parameter int SRAM_READ_LATENCY = c_DEFAULT_SRAM_READ_LATENCY,
  parameter int ADDR_W            = c_DEFAULT_ADDR_W
) (
  input wire logic        Clock,
  input wire logic        Resetn,
  sram_uart_dump_if.slave bus
);

  // Latency counter: 0 while the address is first presented, data sampled at
  // CAPTURE, and in the wait path the first frame is loaded one cycle later.
  localparam int                 c_LAT_W       = $clog2(SRAM_READ_LATENCY + 2);
  localparam logic [c_LAT_W-1:0] c_CAPTURE_CNT = c_LAT_W'(SRAM_READ_LATENCY);
  localparam logic [c_LAT_W-1:0] c_LOAD_CNT    = c_LAT_W'(SRAM_READ_LATENCY + 1);

  dump_state_type    r_state;
  dump_state_type    w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remaining;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [15:0]       r_buffer;
  logic [15:0]       r_prefetch;
  logic [c_LAT_W-1:0] r_lat_cnt;
  logic              r_done;
  logic              w_last_word;
  logic              w_load;
  logic [7:0]        w_tx_data;
  logic              w_busy;
  logic              w_frame_done;
  logic              w_tx;

  assign w_last_word = (r_remaining == ADDR_W'(1));

  always_ff @(posedge Clock) begin
    if (!Resetn) r_state <= S_DUMP_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_DUMP_IDLE:
        if (bus.Start) w_state_nxt = (bus.Word_count == '0) ? S_DUMP_DONE : S_DUMP_FETCH;
      S_DUMP_FETCH: w_state_nxt = S_DUMP_WAIT;
      S_DUMP_WAIT:
        if (r_lat_cnt == c_LOAD_CNT) w_state_nxt = S_DUMP_TX_HI;
      S_DUMP_TX_HI:
        if (w_frame_done) w_state_nxt = S_DUMP_TX_LO;
      S_DUMP_TX_LO:
        if (w_frame_done) w_state_nxt = w_last_word ? S_DUMP_DONE : S_DUMP_TX_HI;
      S_DUMP_DONE:  w_state_nxt = S_DUMP_IDLE;
      default:      w_state_nxt = S_DUMP_IDLE;
    endcase
  end

  // Loads coincide with the previous frame's last stop cycle, giving back-to-back frames.
  always_comb begin
    w_load    = 1'b0;
    w_tx_data = r_buffer[15:8];
    w_busy    = (r_state != S_DUMP_IDLE);
    case (r_state)
      S_DUMP_WAIT: w_load = (r_lat_cnt == c_LOAD_CNT);
      S_DUMP_TX_HI: begin
        w_load    = w_frame_done;
        w_tx_data = r_buffer[7:0];
      end
      S_DUMP_TX_LO: begin
        w_load    = w_frame_done && !w_last_word;
        w_tx_data = r_prefetch[15:8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_sram_addr <= '0;
      r_buffer    <= '0;
      r_prefetch  <= '0;
      r_lat_cnt   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == S_DUMP_DONE);
      if (r_lat_cnt != c_LOAD_CNT) r_lat_cnt <= r_lat_cnt + 1'b1;
      case (r_state)
        S_DUMP_IDLE:
          if (bus.Start) begin
            r_addr      <= bus.Start_address;
            r_remaining <= bus.Word_count;
            r_lat_cnt   <= '0;
            if (bus.Word_count != '0) r_sram_addr <= bus.Start_address;
          end
        S_DUMP_WAIT:
          if (r_lat_cnt == c_CAPTURE_CNT) r_buffer <= bus.SRAM_read_data;
        S_DUMP_TX_HI:
          if (w_frame_done) begin
            r_lat_cnt <= '0;
            if (!w_last_word) r_sram_addr <= r_addr + 1'b1;
          end
        S_DUMP_TX_LO: begin
          if (r_lat_cnt == c_CAPTURE_CNT) r_prefetch <= bus.SRAM_read_data;
          if (w_frame_done && !w_last_word) begin
            r_buffer    <= r_prefetch;
            r_addr      <= r_addr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Load       (w_load),
    .Data       (w_tx_data),
    .TX         (w_tx),
    .Frame_done (w_frame_done)
  );

  assign bus.Busy         = w_busy;
  assign bus.Done         = r_done;
  assign bus.SRAM_address = r_sram_addr;
  assign bus.SRAM_we_n    = 1'b1;
  assign bus.UART_TX_O    = w_tx;

endmodule
`default_nettype wire
